sub_serial: RTL and testbench

- Bit-serial, multi-cycle subtractor: computes diff = A - B - Bin, one bit per clock, LSB first, with a rippling borrow.
- Inverse counterpart of the team's combinational ripple adder: subtract instead of add, sequential instead of single-cycle.
- Sits on a start/done handshake so a controller can issue operations and wait for completion.

---
 rtl/sub_serial.sv | 134 +++++++++++++
 tb/tb_sub_serial.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial subtractor: diff = A - B - Bin, one bit per clock, LSB first, start/done handshake.
// Define SUB_SERIAL_OVF_EN to add the signed overflow output ovf.
module sub_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SUB_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic accept;
    logic ai, bi, d, br_next;

    always_comb begin
        ai      = a_q[cnt_q];
        bi      = b_q[cnt_q];
        d       = ai ^ bi ^ br_q;
        br_next = (~ai & bi) | (~ai & br_q) | (bi & br_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        accept  = 1'b0;

        case (state_q)
            StIdle: begin
                accept = start;
            end
            StShift: begin
                diff_d[cnt_q] = d;
                br_d          = br_next;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    bout_d  = br_next;
`ifdef SUB_SERIAL_OVF_EN
                    ovf_d   = (ai ^ bi) & (d ^ ai);
`endif
                end
            end
            StDone: begin
                // Back-to-back: a start seen in DONE skips the IDLE cycle.
                accept  = start;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d = StShift;
            a_d     = A;
            b_d     = B;
            br_d    = Bin;
            cnt_d   = '0;
            diff_d  = '0;
            bout_d  = 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_SERIAL_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial (WIDTH=4); checks ovf when SUB_SERIAL_OVF_EN is defined.
module tb_sub_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] A, B;
    logic       Bin;
    logic       busy, done, bout;
    logic [3:0] diff;
`ifdef SUB_SERIAL_OVF_EN
    logic       ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sub_serial #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE (called at a negedge) and check busy length and result.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic bin, input logic [3:0] ed, input logic eb,
                          input logic eo);
        int busy_cnt;
        int n;
        A = a; B = b; Bin = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        n = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_len"}, busy_cnt, 4);
        check({tag, "_done"}, {31'd0, done}, 1);
        check({tag, "_diff"}, {28'd0, diff}, {28'd0, ed});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef SUB_SERIAL_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo) begin end
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 0);
        check({tag, "_diff_hold"}, {28'd0, diff}, {28'd0, ed});
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_diff", {28'd0, diff}, 0);
        check("rst_bout", {31'd0, bout}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
        run_op("3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
        run_op("0m0b1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);

        // start and operand changes while busy are ignored
        A = 4'd5; B = 4'd2; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'hF; B = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                done_cnt++;
                check("ign_diff", {28'd0, diff}, 3);
                check("ign_bout", {31'd0, bout}, 0);
            end
            @(negedge clk);
        end
        check("ign_done_cnt", done_cnt, 1);

        // back-to-back with start held through DONE
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        first_done = -1;
        second_done = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin A = 4'd2; B = 4'd5; end
            if (done) begin
                if (first_done < 0) begin
                    first_done = c;
                    check("b2b_diff1", {28'd0, diff}, 6);
                    check("b2b_bout1", {31'd0, bout}, 0);
                end else if (second_done < 0) begin
                    second_done = c;
                    check("b2b_diff2", {28'd0, diff}, 4'hD);
                    check("b2b_bout2", {31'd0, bout}, 1);
                    start = 1'b0;
                end
            end
        end
        check("b2b_first_at", first_done, 5);
        check("b2b_period", second_done - first_done, 5);

        // asynchronous reset during the second SHIFT cycle
        A = 4'd9; B = 4'd2; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_done", {31'd0, done}, 0);
        check("arst_diff", {28'd0, diff}, 0);
        check("arst_bout", {31'd0, bout}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) done_cnt++;
            @(negedge clk);
        end
        check("arst_no_done", done_cnt, 0);
        run_op("7m7", 4'd7, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0);

`ifdef SUB_SERIAL_OVF_EN
        run_op("ovf_8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
        run_op("ovf_7mF", 4'd7, 4'hF, 1'b0, 4'd8, 1'b1, 1'b1);
        run_op("ovf_6m2", 4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
